// File: rtl/locked_mult_key_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : locked_mult_key_sweep_ctrl
// Description : Key-sweep sequencer for a key-locked OP_W x OP_W multiplier.
//               Holds one candidate key on the multiplier key bus, applies
//               NUM_VEC LFSR-generated operand pairs, checks every product
//               against an internal golden multiply and reports the
//               mismatch count and the index of the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module locked_mult_key_sweep_ctrl #(
    parameter int OP_W    = 8,
    parameter int KEY_W   = 32,
    parameter int NUM_VEC = 256,
    parameter int SETTLE  = 1,
    parameter int CNT_W   = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_W-1:0]    key_data,
    input  logic [15:0]         seed,
    input  logic                abort,
    output logic [OP_W-1:0]     dut_op1,
    output logic [OP_W-1:0]     dut_op2,
    output logic [KEY_W-1:0]    dut_key,
    input  logic [2*OP_W-1:0]   dut_product,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [KEY_W-1:0]    res_key,
    output logic [CNT_W-1:0]    res_err_count,
    output logic [CNT_W-1:0]    res_first_err,
    output logic                busy
);

    // The vector index gets its own width so that a narrow error counter
    // never limits how many vectors can be walked per key.
    localparam int IDX_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_check  = 3'd3;
    localparam logic [2:0] c_st_report = 3'd4;

    localparam logic [IDX_W-1:0]  c_last_idx   = IDX_W'(NUM_VEC - 1);
    localparam logic [WCNT_W-1:0] c_wcnt_init  = WCNT_W'(SETTLE - 1);
    localparam logic [15:0]       c_zero_seed  = 16'hACE1;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [15:0]         r_lfsr;
    logic [15:0]         w_lfsr_step;
    logic [IDX_W-1:0]    r_idx;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]    r_err;
    logic [CNT_W-1:0]    r_first_err;
    logic [2*OP_W-1:0]   w_golden;
    logic                w_mismatch;
    logic                w_accept;
    logic                w_in_sweep;
    logic                w_abort_hit;
    logic                w_last_vec;

    // Golden product is taken at full width so no carry bits are lost.
    assign w_golden    = {{OP_W{1'b0}}, dut_op1} * {{OP_W{1'b0}}, dut_op2};
    assign w_mismatch  = (dut_product != w_golden);

    // Fibonacci LFSR, taps for x^16 + x^14 + x^13 + x^11 + 1.
    assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    assign w_accept    = key_valid && key_ready;
    assign w_in_sweep  = (r_state == c_st_load) || (r_state == c_st_wait) ||
                         (r_state == c_st_check);
    assign w_abort_hit = abort && w_in_sweep;
    assign w_last_vec  = (r_idx == c_last_idx);

    // The result key is simply the key still held on the multiplier bus.
    assign res_key       = dut_key;
    assign res_err_count = r_err;
    assign res_first_err = r_first_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort overrides every sweep transition, including
    // the final CHECK that would otherwise enter REPORT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = c_st_load;
                end
            end
            c_st_load: begin
                w_state_next = abort ? c_st_idle : c_st_wait;
            end
            c_st_wait: begin
                if (abort) begin
                    w_state_next = c_st_idle;
                end else if (r_wcnt == '0) begin
                    w_state_next = c_st_check;
                end
            end
            c_st_check: begin
                if (abort) begin
                    w_state_next = c_st_idle;
                end else if (w_last_vec) begin
                    w_state_next = c_st_report;
                end else begin
                    w_state_next = c_st_load;
                end
            end
            c_st_report: begin
                if (res_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        key_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            c_st_idle: begin
                key_ready = 1'b1;
                busy      = 1'b0;
            end
            c_st_report: begin
                res_valid = 1'b1;
            end
            default: begin
                key_ready = 1'b0;
            end
        endcase
    end

    // Sweep datapath: key/seed capture, operand launch, settle count and
    // product check. Operands and key are only written in LOAD and IDLE, so
    // they hold through REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= '0;
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_err       <= '0;
            r_first_err <= '1;
            dut_op1     <= '0;
            dut_op2     <= '0;
            dut_key     <= '0;
        end else if (w_abort_hit) begin
            // A cancelled sweep leaves no partial result behind.
            r_err       <= '0;
            r_first_err <= '1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        dut_key     <= key_data;
                        r_lfsr      <= (seed == 16'h0000) ? c_zero_seed : seed;
                        r_idx       <= '0;
                        r_err       <= '0;
                        r_first_err <= '1;
                    end
                end
                c_st_load: begin
                    dut_op1 <= OP_W'(r_lfsr[15:8]);
                    dut_op2 <= OP_W'(r_lfsr[7:0]);
                    r_wcnt  <= c_wcnt_init;
                end
                c_st_wait: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                c_st_check: begin
                    if (w_mismatch) begin
                        if (!(&r_err)) begin
                            r_err <= r_err + 1'b1;
                        end
                        if (&r_first_err) begin
                            r_first_err <= CNT_W'(r_idx);
                        end
                    end
                    r_lfsr <= w_lfsr_step;
                    if (!w_last_vec) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_wcnt <= r_wcnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_locked_mult_key_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_locked_mult_key_sweep_ctrl
// Description : Self-checking bench for locked_mult_key_sweep_ctrl with a
//               behavioural multiplier stub and a sweep-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_locked_mult_key_sweep_ctrl;

    localparam int NV    = 16;
    localparam int SET   = 1;
    localparam int CW    = 9;
    localparam int PER   = 2 + SET;
    localparam int S_SET = 2;
    localparam int S_CW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Primary instance signals
    logic        rst;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] key_data;
    logic [15:0] seed;
    logic        abort;
    logic [7:0]  dut_op1;
    logic [7:0]  dut_op2;
    logic [31:0] dut_key;
    logic [15:0] dut_product;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_key;
    logic [CW-1:0] res_err_count;
    logic [CW-1:0] res_first_err;
    logic        busy;
    logic [1:0]  mode;

    // Narrow-counter instance signals
    logic        s_key_valid;
    logic        s_key_ready;
    logic [7:0]  s_op1;
    logic [7:0]  s_op2;
    logic [31:0] s_dut_key;
    logic [15:0] s_product;
    logic        s_res_valid;
    logic        s_res_ready;
    logic [31:0] s_res_key;
    logic [S_CW-1:0] s_err;
    logic [S_CW-1:0] s_first;
    logic        s_busy;

    int vectors;
    int miscompares;

    logic [7:0] exp_op1 [NV];
    logic [7:0] exp_op2 [NV];
    logic [7:0] obs_op1 [NV];
    logic [7:0] obs_op2 [NV];

    locked_mult_key_sweep_ctrl #(
        .OP_W(8), .KEY_W(32), .NUM_VEC(NV), .SETTLE(SET), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key_data(key_data), .seed(seed), .abort(abort),
        .dut_op1(dut_op1), .dut_op2(dut_op2), .dut_key(dut_key),
        .dut_product(dut_product), .res_valid(res_valid), .res_ready(res_ready),
        .res_key(res_key), .res_err_count(res_err_count),
        .res_first_err(res_first_err), .busy(busy)
    );

    locked_mult_key_sweep_ctrl #(
        .OP_W(8), .KEY_W(32), .NUM_VEC(NV), .SETTLE(S_SET), .CNT_W(S_CW)
    ) u_sat (
        .clk(clk), .rst(rst), .key_valid(s_key_valid), .key_ready(s_key_ready),
        .key_data(32'hCAFE_0003), .seed(16'h1234), .abort(1'b0),
        .dut_op1(s_op1), .dut_op2(s_op2), .dut_key(s_dut_key),
        .dut_product(s_product), .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_key(s_res_key), .res_err_count(s_err),
        .res_first_err(s_first), .busy(s_busy)
    );

    // Multiplier stub: 0 ideal, 1 always off by one bit, 2 wrong only for 3*5,
    // 3 wrong whenever the operands share their two low bits.
    function automatic logic [15:0] stub_product(input logic [1:0] m, input logic [7:0] a,
                                                 input logic [7:0] b);
        logic [15:0] g;
        g = {8'h00, a} * {8'h00, b};
        case (m)
            2'd0:    return g;
            2'd1:    return g ^ 16'h0001;
            2'd2:    return (a == 8'd3 && b == 8'd5) ? (g ^ 16'h0100) : g;
            default: return (a[1:0] == b[1:0]) ? (g ^ 16'h8000) : g;
        endcase
    endfunction

    always_comb dut_product = stub_product(mode, dut_op1, dut_op2);
    always_comb s_product   = stub_product(2'd1, s_op1, s_op2);

    // Sweep-level reference: operand list from the LFSR rule, mismatches
    // counted against a plain multiply, counter capped at cnt_max.
    task automatic model_run(input logic [15:0] s, input logic [1:0] m, input int cnt_max,
                             output int e_err, output int e_first);
        logic [15:0] l;
        logic [7:0]  a;
        logic [7:0]  b;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        e_err   = 0;
        e_first = -1;
        for (int v = 0; v < NV; v++) begin
            a = l[15:8];
            b = l[7:0];
            exp_op1[v] = a;
            exp_op2[v] = b;
            if (stub_product(m, a, b) != (16'(a) * 16'(b))) begin
                if (e_err < cnt_max) e_err++;
                if (e_first < 0) e_first = v;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    // Offer one key, then follow the sweep collecting operands until
    // res_valid rises; lat is -1 if it never does within the budget.
    task automatic run_key(input logic [31:0] k, input logic [15:0] s, output int lat);
        int n;
        n = 0;
        while (!key_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        key_valid = 1'b1;
        key_data  = k;
        seed      = s;
        @(posedge clk); #1;
        key_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if ((c - 1) % PER == 0 && (c - 1) / PER < NV) begin
                obs_op1[(c - 1) / PER] = dut_op1;
                obs_op2[(c - 1) / PER] = dut_op2;
            end
            if (res_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++; if (key_ready !== 1'b1) begin miscompares++; $display("FAIL reset_key_ready got %b want 1", key_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if ({dut_op1, dut_op2} !== 16'h0) begin miscompares++; $display("FAIL reset_ops got %h want 0000", {dut_op1, dut_op2}); end
        vectors++; if (dut_key !== 32'h0 || res_key !== 32'h0) begin miscompares++; $display("FAIL reset_key got %h/%h want 0", dut_key, res_key); end
        vectors++; if (res_err_count !== '0) begin miscompares++; $display("FAIL reset_err got %0d want 0", res_err_count); end
        vectors++; if (res_first_err !== {CW{1'b1}}) begin miscompares++; $display("FAIL reset_first_err got %h want all-ones", res_first_err); end
    endtask

    // Directed and randomized sweeps against the reference model.
    task automatic test_sweeps();
        logic [31:0] k;
        logic [15:0] s;
        logic [1:0]  m;
        int lat, e_err, e_first, bad_ops;
        for (int t = 0; t < 8; t++) begin
            k = $urandom;
            s = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            if (t == 0) begin k = 32'h1; m = 2'd0; end
            if (t == 1) m = 2'd1;
            if (t == 2) begin s = 16'h0305; m = 2'd2; end
            if (s == 16'h0000) s = 16'h0001;
            mode = m;
            model_run(s, m, (1 << CW) - 1, e_err, e_first);
            run_key(k, s, lat);
            vectors++; if (lat !== NV * PER) begin miscompares++; $display("FAIL sweep%0d_latency got %0d want %0d", t, lat, NV * PER); end
            vectors++; if (res_err_count !== CW'(e_err)) begin miscompares++; $display("FAIL sweep%0d_err got %0d want %0d", t, res_err_count, e_err); end
            vectors++; if (res_first_err !== ((e_first < 0) ? {CW{1'b1}} : CW'(e_first))) begin miscompares++; $display("FAIL sweep%0d_first_err got %0d want %0d", t, res_first_err, e_first); end
            vectors++; if (res_key !== k || dut_key !== k) begin miscompares++; $display("FAIL sweep%0d_key got %h want %h", t, res_key, k); end
            bad_ops = 0;
            for (int v = 0; v < NV; v++) if (obs_op1[v] !== exp_op1[v] || obs_op2[v] !== exp_op2[v]) bad_ops++;
            vectors++; if (bad_ops != 0) begin miscompares++; $display("FAIL sweep%0d_operands got %0d bad vectors want 0", t, bad_ops); end
            vectors++; if (busy !== 1'b1 || key_ready !== 1'b0) begin miscompares++; $display("FAIL sweep%0d_report_flags got busy=%b ready=%b want 1/0", t, busy, key_ready); end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            vectors++; if (key_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL sweep%0d_release got ready=%b valid=%b want 1/0", t, key_ready, res_valid); end
        end
    endtask

    // Host stalls the result while already offering the next key.
    task automatic test_back_to_back();
        int lat, e_err, e_first, bad;
        mode = 2'd3;
        model_run(16'hBEEF, 2'd3, (1 << CW) - 1, e_err, e_first);
        run_key(32'h1111_2222, 16'hBEEF, lat);
        key_valid = 1'b1;
        key_data  = 32'h3333_4444;
        seed      = 16'h0042;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || key_ready !== 1'b0 || res_key !== 32'h1111_2222 ||
                res_err_count !== CW'(e_err) ||
                res_first_err !== ((e_first < 0) ? {CW{1'b1}} : CW'(e_first))) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_report got %0d unstable cycles want 0", bad); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        vectors++; if (key_ready !== 1'b1 || busy !== 1'b0 || dut_key !== 32'h1111_2222) begin miscompares++; $display("FAIL b2b_after_handshake got ready=%b busy=%b key=%h want 1/0/11112222", key_ready, busy, dut_key); end
        @(posedge clk); #1;
        key_valid = 1'b0;
        vectors++; if (busy !== 1'b1 || dut_key !== 32'h3333_4444) begin miscompares++; $display("FAIL b2b_accept got busy=%b key=%h want 1/33334444", busy, dut_key); end
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (res_valid) begin lat = c; break; end
        end
        vectors++; if (lat < 0) begin miscompares++; $display("FAIL b2b_second_result got timeout want res_valid"); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        int lat, e_err, e_first, seen;
        // abort in WAIT of vector 5, then abort racing the final CHECK
        for (int pass = 0; pass < 2; pass++) begin
            mode = 2'd1;
            key_valid = 1'b1;
            key_data  = 32'hABCD_0000 + pass;
            seed      = 16'h5A5A;
            @(posedge clk); #1;
            key_valid = 1'b0;
            for (int c = 1; c <= ((pass == 0) ? 1 + 5 * PER : NV * PER - 1); c++) begin
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            vectors++; if (busy !== 1'b0 || key_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL abort%0d_to_idle got busy=%b ready=%b valid=%b want 0/1/0", pass, busy, key_ready, res_valid); end
            seen = 0;
            for (int c = 0; c < 60; c++) begin
                @(posedge clk); #1;
                if (res_valid) seen++;
            end
            vectors++; if (seen != 0) begin miscompares++; $display("FAIL abort%0d_no_result got %0d valid cycles want 0", pass, seen); end
        end
        // abort in REPORT is ignored
        mode = 2'd0;
        model_run(16'h2468, 2'd0, (1 << CW) - 1, e_err, e_first);
        run_key(32'h0BAD_F00D, 16'h2468, lat);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL abort_in_report got valid=%b want 1", res_valid); end
        vectors++; if (lat !== NV * PER || res_err_count !== CW'(e_err) || res_first_err !== {CW{1'b1}}) begin miscompares++; $display("FAIL abort_restart got lat=%0d err=%0d first=%h want %0d/%0d/all-ones", lat, res_err_count, res_first_err, NV * PER, e_err); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        int lat;
        mode = 2'd1;
        key_valid = 1'b1;
        key_data  = 32'h7777_7777;
        seed      = 16'h0F0F;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (key_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_check_flags got ready=%b busy=%b valid=%b want 1/0/0", key_ready, busy, res_valid); end
        vectors++; if ({dut_op1, dut_op2} !== 16'h0 || dut_key !== 32'h0 || res_err_count !== '0 || res_first_err !== {CW{1'b1}}) begin miscompares++; $display("FAIL rst_check_data got ops=%h key=%h err=%0d first=%h want reset values", {dut_op1, dut_op2}, dut_key, res_err_count, res_first_err); end
        run_key(32'h8888_8888, 16'h1357, lat);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (res_valid !== 1'b0 || key_ready !== 1'b1 || res_err_count !== '0) begin miscompares++; $display("FAIL rst_report got valid=%b ready=%b err=%0d want 0/1/0", res_valid, key_ready, res_err_count); end
    endtask

    task automatic test_seed_zero();
        int lat;
        mode = 2'd0;
        run_key(32'h0000_0A0A, 16'h0000, lat);
        vectors++; if (obs_op1[0] !== 8'hAC || obs_op2[0] !== 8'hE1) begin miscompares++; $display("FAIL seed_zero_vec0 got %h/%h want ac/e1", obs_op1[0], obs_op2[0]); end
        vectors++; if (lat !== NV * PER || res_err_count !== '0) begin miscompares++; $display("FAIL seed_zero_result got lat=%0d err=%0d want %0d/0", lat, res_err_count, NV * PER); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_saturate();
        int lat;
        s_key_valid = 1'b1;
        @(posedge clk); #1;
        s_key_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (s_res_valid) begin lat = c; break; end
        end
        vectors++; if (lat !== NV * (2 + S_SET)) begin miscompares++; $display("FAIL sat_latency got %0d want %0d", lat, NV * (2 + S_SET)); end
        vectors++; if (s_err !== 3'd7 || s_first !== 3'd0) begin miscompares++; $display("FAIL sat_counts got err=%0d first=%0d want 7/0", s_err, s_first); end
        vectors++; if (s_res_key !== 32'hCAFE_0003 || s_dut_key !== 32'hCAFE_0003 || s_busy !== 1'b1 || s_key_ready !== 1'b0) begin miscompares++; $display("FAIL sat_report got key=%h busy=%b ready=%b want cafe0003/1/0", s_res_key, s_busy, s_key_ready); end
        s_res_ready = 1'b1;
        @(posedge clk); #1;
        s_res_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        key_valid   = 1'b0;
        key_data    = '0;
        seed        = '0;
        abort       = 1'b0;
        res_ready   = 1'b0;
        mode        = 2'd0;
        s_key_valid = 1'b0;
        s_res_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_sweeps();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        test_seed_zero();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
